// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that merges an instruction-fetch port and a data port onto one
// memory port with a single outstanding access. Optional feature macro: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_size_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2,
    ERR_RSP     = 2'd3
  } state_e;

  localparam logic OWN_D  = 1'b0;
  localparam logic OWN_IF = 1'b1;
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << off;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   lane_wdata = {4{wdata[7:0]}};
      2'b01:   lane_wdata = {2{wdata[15:0]}};
      default: lane_wdata = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_align(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'b00:   load_align = {24'h000000, sh[7:0]};
      2'b01:   load_align = {16'h0000, sh[15:0]};
      default: load_align = sh;
    endcase
  endfunction

  state_e            state_q, state_d;
  logic              last_owner_q, last_owner_d;
  logic              owner_q, owner_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        off_q, off_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic pick_d_s, pick_if_s, grant_s, d_mis_s;
  logic timeout_s, mem_rsp_s, rsp_err_s, done_s;

  // Data wins a tie only when fetch owned the previous transaction.
  assign pick_d_s  = d_req_i & (~if_req_i | (last_owner_q == OWN_IF));
  assign pick_if_s = if_req_i & ~pick_d_s;
  assign grant_s   = (state_q == IDLE) & (if_req_i | d_req_i);
  assign d_mis_s   = misaligned(d_size_i, d_addr_i[1:0]);
  assign if_gnt_o  = grant_s & pick_if_s;
  assign d_gnt_o   = grant_s & pick_d_s;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       waiting_s;

  assign waiting_s = (state_q == WAIT_GNT) | (state_q == WAIT_RVALID);
  // A real response arriving in the final cycle beats the timeout.
  assign timeout_s = waiting_s & (cnt_q == 8'hFF) & ~((state_q == WAIT_RVALID) & mem_rvalid_i);

  // Wait-cycle counter: cleared at grant, advances while the access is in flight.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_s) begin
      cnt_d = 8'h00;
    end else if (waiting_s) begin
      cnt_d = cnt_q + 8'h01;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'h00;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_s = 1'b0;
`endif

  assign mem_rsp_s = (state_q == WAIT_RVALID) & mem_rvalid_i;
  assign rsp_err_s = (state_q == ERR_RSP) | timeout_s;
  assign done_s    = mem_rsp_s | rsp_err_s;

  assign if_rvalid_o = done_s & (owner_q == OWN_IF);
  assign d_rvalid_o  = done_s & (owner_q == OWN_D);
  assign d_err_o     = rsp_err_s & (owner_q == OWN_D);
`ifdef MEM_ARB_TIMEOUT_EN
  assign if_err_o    = rsp_err_s & (owner_q == OWN_IF);
`else
  assign if_err_o    = 1'b0;
`endif
  assign if_rdata_o  = (if_rvalid_o & ~rsp_err_s) ? mem_rdata_i : {DATA_W{1'b0}};
  assign d_rdata_o   = (d_rvalid_o & ~rsp_err_s & ~mem_we_q) ?
                       load_align(size_q, off_q, mem_rdata_i) : {DATA_W{1'b0}};

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  // Next-state and latched-field logic for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    size_d       = size_q;
    off_d        = off_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          last_owner_d = pick_if_s;
          owner_d      = pick_if_s;
          size_d       = d_size_i;
          off_d        = d_addr_i[1:0];
          if (pick_if_s) begin
            state_d    = WAIT_GNT;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_be_d   = 4'b1111;
            mem_addr_d = if_addr_i & WORD_MASK;
          end else if (d_mis_s) begin
            state_d   = ERR_RSP;
            mem_req_d = 1'b0;
          end else begin
            state_d     = WAIT_GNT;
            mem_req_d   = 1'b1;
            mem_we_d    = d_we_i;
            mem_be_d    = lane_be(d_size_i, d_addr_i[1:0]);
            mem_addr_d  = d_addr_i & WORD_MASK;
            mem_wdata_d = lane_wdata(d_size_i, d_wdata_i);
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_GNT: begin
        if (timeout_s) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else if (mem_gnt_i) begin
          state_d   = WAIT_RVALID;
          mem_req_d = 1'b0;
        end else begin
          state_d = WAIT_GNT;
        end
      end
      WAIT_RVALID: begin
        if (timeout_s | mem_rvalid_i) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RVALID;
        end
      end
      ERR_RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_IF;
      owner_q      <= OWN_D;
      size_q       <= 2'b00;
      off_q        <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 4'b0000;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      size_q       <= size_d;
      off_q        <= off_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed multi-cycle
// sequences and randomized transactions against a behavioural model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, if_gnt_o, if_rvalid_o, if_err_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        d_req_i, d_we_i, d_gnt_o, d_rvalid_o, d_err_o;
  logic [1:0]  d_size_i;
  logic [31:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_size_i(d_size_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic        rq_if;
    logic        rq_d;
    logic [31:0] if_addr;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    logic        e_if_win;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  logic m_last;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req_i = 1'b0; if_addr_i = 32'h0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_size_i = 2'b00; d_addr_i = 32'h0; d_wdata_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle_inputs();
    @(negedge clk); @(negedge clk); rst = 1'b0; m_last = 1'b1;
  endtask

  // Reference model: arbitration and lane arithmetic derived from the access rules.
  function automatic vec_t model(input vec_t v, input logic last);
    vec_t r;
    int nb, off;
    logic [31:0] msk;
    r = v;
    r.e_we = 1'b0; r.e_be = 4'h0; r.e_addr = 32'h0; r.e_wdata = 32'h0;
    r.e_rdata = 32'h0; r.e_err = 1'b0;
    r.e_if_win = v.rq_if && (!v.rq_d || !last);
    if (r.e_if_win) begin
      r.e_be = 4'hF; r.e_addr = v.if_addr - (v.if_addr % 32'd4); r.e_rdata = v.mem_rdata;
    end else begin
      nb  = (v.d_size == 2'd0) ? 1 : (v.d_size == 2'd1) ? 2 : (v.d_size == 2'd2) ? 4 : 0;
      off = int'(v.d_addr % 32'd4);
      if (nb == 0) r.e_err = 1'b1;
      else         r.e_err = (v.d_addr % nb) != 0;
      msk = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      r.e_we    = v.d_we;
      r.e_be    = 4'(((1 << nb) - 1) << off);
      r.e_addr  = v.d_addr - off;
      r.e_wdata = (nb == 1) ? (v.d_wdata & msk) * 32'h0101_0101 :
                  (nb == 2) ? (v.d_wdata & msk) * 32'h0001_0001 : v.d_wdata;
      r.e_rdata = (v.mem_rdata >> (8 * off)) & msk;
    end
    return r;
  endfunction

  // One complete transaction: grant, memory handshake after gw/rw idle cycles, response.
  task automatic run_txn(input vec_t v, input int gw, input int rw);
    @(negedge clk);
    if_req_i = v.rq_if; if_addr_i = v.if_addr; d_req_i = v.rq_d; d_we_i = v.d_we;
    d_size_i = v.d_size; d_addr_i = v.d_addr; d_wdata_i = v.d_wdata;
    #2;
    chk("if_gnt", 32'(if_gnt_o), 32'(v.e_if_win));
    chk("d_gnt", 32'(d_gnt_o), 32'(!v.e_if_win));
    m_last = v.e_if_win;
    @(negedge clk); if_req_i = 1'b0; d_req_i = 1'b0;
    #2;
    if (v.e_err) begin
      chk("err_rvalid", 32'(d_rvalid_o), 32'd1);
      chk("err_flag", 32'(d_err_o), 32'd1);
      chk("err_rdata", d_rdata_o, 32'h0);
      chk("err_memreq", 32'(mem_req_o), 32'd0);
      @(negedge clk); #2;
      chk("err_pulse_end", 32'(d_rvalid_o), 32'd0);
      chk("err_memreq_after", 32'(mem_req_o), 32'd0);
    end else begin
      chk("mem_req", 32'(mem_req_o), 32'd1);
      chk("mem_be", 32'(mem_be_o), 32'(v.e_be));
      chk("mem_addr", mem_addr_o, v.e_addr);
      chk("mem_we", 32'(mem_we_o), 32'(v.e_we));
      if (v.e_we) chk("mem_wdata", mem_wdata_o, v.e_wdata);
      for (int i = 0; i < gw; i++) begin
        @(negedge clk); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0; #2;
        chk("req_hold", 32'(mem_req_o), 32'd1);
        chk("addr_stable", mem_addr_o, v.e_addr);
        chk("stray_rvalid", 32'(if_rvalid_o | d_rvalid_o), 32'd0);
      end
      @(negedge clk); mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; #2;
      chk("req_at_gnt", 32'(mem_req_o), 32'd1);
      @(negedge clk); mem_gnt_i = 1'b0; #2;
      chk("req_drop", 32'(mem_req_o), 32'd0);
      chk("early_rvalid", 32'(if_rvalid_o | d_rvalid_o), 32'd0);
      for (int i = 0; i < rw; i++) begin
        @(negedge clk); #2;
        chk("wait_rvalid", 32'(if_rvalid_o | d_rvalid_o), 32'd0);
      end
      @(negedge clk); mem_rvalid_i = 1'b1; mem_rdata_i = v.mem_rdata; #2;
      chk("if_rvalid", 32'(if_rvalid_o), 32'(v.e_if_win));
      chk("d_rvalid", 32'(d_rvalid_o), 32'(!v.e_if_win));
      chk("rsp_err", 32'(if_err_o | d_err_o), 32'd0);
      if (v.e_if_win)  chk("if_rdata", if_rdata_o, v.e_rdata);
      else if (!v.e_we) chk("d_rdata", d_rdata_o, v.e_rdata);
      @(negedge clk); mem_rvalid_i = 1'b0; #2;
      chk("rvalid_pulse", 32'(if_rvalid_o | d_rvalid_o), 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = '{1'b1, 1'b0, 32'h100, 1'b0, 2'b00, 32'h0,   32'h0,        32'h0000_0013,
                1'b1, 1'b0, 4'b1111, 32'h100, 32'h0,        32'h0000_0013, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h107, 1'b0, 2'b00, 32'h0,   32'h0,        32'hDEAD_BEEF,
                1'b1, 1'b0, 4'b1111, 32'h104, 32'h0,        32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32'h0,   1'b1, 2'b00, 32'h203, 32'h0000_00AB, 32'h0,
                1'b0, 1'b1, 4'b1000, 32'h200, 32'hABAB_ABAB, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0,   1'b1, 2'b01, 32'h102, 32'h0000_1234, 32'h0,
                1'b0, 1'b1, 4'b1100, 32'h100, 32'h1234_1234, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 1'b1, 32'h0,   1'b1, 2'b10, 32'h40,  32'hCAFE_F00D, 32'h0,
                1'b0, 1'b1, 4'b1111, 32'h40,  32'hCAFE_F00D, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h0,   1'b0, 2'b01, 32'h202, 32'h0,        32'hBEEF_1234,
                1'b0, 1'b0, 4'b1100, 32'h200, 32'h0,        32'h0000_BEEF, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h0,   1'b0, 2'b00, 32'h301, 32'h0,        32'h1122_3344,
                1'b0, 1'b0, 4'b0010, 32'h300, 32'h0,        32'h0000_0033, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'h0,   1'b0, 2'b10, 32'h208, 32'h0,        32'h89AB_CDEF,
                1'b0, 1'b0, 4'b1111, 32'h208, 32'h0,        32'h89AB_CDEF, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 32'h0,   1'b0, 2'b10, 32'h205, 32'h0,        32'h0,
                1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0,         1'b1};
    tbl[9]  = '{1'b0, 1'b1, 32'h0,   1'b0, 2'b01, 32'h001, 32'h0,        32'h0,
                1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0,         1'b1};
    tbl[10] = '{1'b0, 1'b1, 32'h0,   1'b1, 2'b11, 32'h0,   32'h0,        32'h0,
                1'b0, 1'b0, 4'b0000, 32'h0,   32'h0,        32'h0,         1'b1};

    rst = 1'b1; idle_inputs();
    repeat (3) @(negedge clk);
    #2;
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_be", 32'(mem_be_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk("rst_rvalid", 32'(if_rvalid_o | d_rvalid_o), 32'd0);
    chk("rst_err", 32'(if_err_o | d_err_o), 32'd0);
    chk("rst_rdata", if_rdata_o | d_rdata_o, 32'h0);
    @(negedge clk); rst = 1'b0; m_last = 1'b1;

    for (int i = 0; i < 11; i++) run_txn(tbl[i], 1, 0);

    // Both ports request every cycle: grants alternate D, IF, D, IF.
    do_reset();
    d_we_i = 1'b0; d_size_i = 2'b10; d_addr_i = 32'h10; if_addr_i = 32'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); mem_rvalid_i = 1'b0; if_req_i = 1'b1; d_req_i = 1'b1; #2;
      chk("alt_d_gnt", 32'(d_gnt_o), 32'(k % 2 == 0));
      chk("alt_if_gnt", 32'(if_gnt_o), 32'(k % 2 == 1));
      m_last = (k % 2 == 1);
      @(negedge clk); mem_gnt_i = 1'b1; #2;
      chk("alt_one_outstanding", 32'(if_gnt_o | d_gnt_o), 32'd0);
      chk("alt_mem_req", 32'(mem_req_o), 32'd1);
      @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'(k); #2;
      chk("alt_rsp", 32'((k % 2 == 1) ? if_rvalid_o : d_rvalid_o), 32'd1);
      chk("alt_no_overlap", 32'(if_gnt_o | d_gnt_o), 32'd0);
    end
    @(negedge clk); mem_rvalid_i = 1'b0; if_req_i = 1'b0; d_req_i = 1'b0;

    // Reset during WAIT_GNT drops mem_req_o on the next cycle.
    @(negedge clk); d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = 2'b10; d_addr_i = 32'h30; #2;
    chk("abort1_gnt", 32'(d_gnt_o), 32'd1);
    @(negedge clk); d_req_i = 1'b0; #2;
    chk("abort1_req", 32'(mem_req_o), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; m_last = 1'b1; #2;
    chk("abort1_req_drop", 32'(mem_req_o), 32'd0);

    // Reset during WAIT_RVALID, then a late response must be ignored.
    @(negedge clk); d_req_i = 1'b1; #2;
    chk("abort2_gnt", 32'(d_gnt_o), 32'd1);
    @(negedge clk); d_req_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk); mem_gnt_i = 1'b0; rst = 1'b1; #2;
    chk("abort2_no_rsp_yet", 32'(d_rvalid_o), 32'd0);
    @(negedge clk); rst = 1'b0; m_last = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA; #2;
    chk("abort2_late_ignored", 32'(d_rvalid_o | if_rvalid_o), 32'd0);
    @(negedge clk); mem_rvalid_i = 1'b0;
    run_txn(tbl[0], 1, 0);

    for (int t = 0; t < 40; t++) begin
      vec_t v;
      int   r;
      r = int'($urandom_range(1, 3));
      v.rq_if = r[0]; v.rq_d = r[1];
      v.if_addr = $urandom; v.d_we = 1'($urandom_range(0, 1));
      v.d_size = 2'($urandom_range(0, 3)); v.d_addr = $urandom & 32'h0000_0FFF;
      v.d_wdata = $urandom; v.mem_rdata = $urandom;
      v = model(v, m_last);
      run_txn(v, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Memory never grants.
    @(negedge clk); d_req_i = 1'b1; d_we_i = 1'b0; d_size_i = 2'b10; d_addr_i = 32'h40;
    @(negedge clk); d_req_i = 1'b0; #2;
    n = 0;
`ifdef MEM_ARB_TIMEOUT_EN
    while (!d_rvalid_o && n < 400) begin
      n++;
      @(negedge clk); #2;
    end
    chk("timeout_cycles", 32'(n), 32'd255);
    chk("timeout_err", 32'(d_err_o), 32'd1);
    chk("timeout_rdata", d_rdata_o, 32'h0);
    @(negedge clk); mem_rvalid_i = 1'b1; #2;
    chk("timeout_req_drop", 32'(mem_req_o), 32'd0);
    chk("timeout_late_ignored", 32'(d_rvalid_o | if_rvalid_o), 32'd0);
    @(negedge clk); mem_rvalid_i = 1'b0;
`else
    repeat (300) begin
      if (mem_req_o === 1'b1 && d_rvalid_o === 1'b0) n++;
      @(negedge clk); #2;
    end
    chk("no_timeout_hold", 32'(n), 32'd300);
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width (only 32 is supported).
REQ-002 SHALL have ports, one per line, in this order:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  reset; synchronous and active-high.
- if_req_i  in  1  instruction-fetch request; held until if_gnt_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  fetch request accepted.
- if_rvalid_o  out  1  fetch response valid.
- if_rdata_o  out  32  fetched instruction word.
- if_err_o  out  1  fetch error; qualifies if_rvalid_o.
- d_req_i  in  1  data request; held until d_gnt_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_size_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- d_addr_i  in  ADDR_W  byte address.
- d_wdata_i  in  32  store data, right-justified.
- d_gnt_o  out  1  data request accepted.
- d_rvalid_o  out  1  data response valid (loads and stores).
- d_rdata_o  out  32  load data, zero-extended, right-justified.
- d_err_o  out  1  data error; qualifies d_rvalid_o.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  ADDR_W  word-aligned address (bits [1:0] = 0).
- mem_wdata_o  out  32  lane-placed store data.
- mem_gnt_i  in  1  memory accepted request.
- mem_rvalid_i  in  1  memory response, one per granted request.
- mem_rdata_i  in  32  memory read word.

Function
REQ-003 SHALL implement FSM IDLE, WAIT_GNT, WAIT_RVALID, ERR_RSP; exactly one transaction outstanding.
REQ-004 In IDLE with a request pending: SHALL assert the winner's gnt combinationally that cycle, latch its fields, and go to WAIT_GNT (ERR_RSP if misaligned).
REQ-005 Arbitration SHALL be round-robin on a last_owner bit; with both requests pending, the requester not granted last wins; a single requester always wins.
REQ-006 mem_req_o SHALL be registered, high from the cycle after gnt until the cycle mem_gnt_i=1 (inclusive); mem_* outputs stay stable while mem_req_o=1.
REQ-007 WAIT_GNT -> WAIT_RVALID on mem_gnt_i; WAIT_RVALID -> IDLE on mem_rvalid_i, pulsing the owner's rvalid for exactly that cycle with rdata combinational from mem_rdata_i.
REQ-008 A new request SHALL be granted at the earliest in the cycle after the rvalid pulse (no back-to-back overlap).
REQ-009 Byte enables: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111; fetch 1111 with we=0.
REQ-010 Store data SHALL be replicated to all lanes (byte x4, half x2); loads SHALL shift right by 8*a[1:0] and zero-extend to the access size.
REQ-011 Misaligned (half with a[0]=1, word with a[1:0]!=0, or size 11) SHALL NOT reach memory: ERR_RSP pulses d_rvalid_o and d_err_o with d_rdata_o=0 the cycle after gnt, then IDLE.
REQ-012 Fetch addresses SHALL have a[1:0] forced to 0; fetches never raise misaligned error.
REQ-013 mem_rvalid_i in IDLE or WAIT_GNT SHALL be ignored.

Reset
REQ-014 On rst: state IDLE, last_owner = fetch (data wins the first tie), all outputs 0, latched fields 0, counter 0.
REQ-015 rst mid-transaction SHALL drop mem_req_o the next cycle and generate no response for the aborted access.

Configuration
REQ-016 MEM_ARB_TIMEOUT_EN defined: an 8-bit counter runs in WAIT_GNT/WAIT_RVALID; on reaching 255, mem_req_o drops and the owner gets rvalid+err with rdata 0, then IDLE (late mem_rvalid_i ignored per REQ-013).
REQ-017 MEM_ARB_TIMEOUT_EN undefined: no counter, waits indefinitely; if_err_o tied 0.

Verification
REQ-018 Fetch 0x100, mem_gnt_i cycle +2, rvalid +4 with rdata 0x00000013 -> if_rvalid_o=1, if_rdata_o=0x00000013, if_err_o=0.
REQ-019 Both request every cycle after reset -> grants alternate D, IF, D, IF; never two outstanding.
REQ-020 Byte store 0xAB to 0x203 -> mem_be_o=1000, mem_addr_o=0x200, mem_wdata_o=0xABABABAB, mem_we_o=1.
REQ-021 Half load 0x202, mem_rdata_i=0xBEEF1234 -> d_rdata_o=0x0000BEEF; word load 0x205 -> d_err_o=1, mem_req_o stays 0.
REQ-022 rst asserted during WAIT_RVALID then late mem_rvalid_i -> no d_rvalid_o/if_rvalid_o; next request served normally.
REQ-023 With MEM_ARB_TIMEOUT_EN, mem_gnt_i held 0 -> err response after 255 cycles in WAIT_GNT; without it, mem_req_o stays 1 indefinitely.
